nonrestoring_divider: RTL and testbench
=======================================

NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-009 SHALL have port: quotient  output  WIDTH  registered unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  registered unsigned remainder.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag; valid with done.

Function
REQ-012 SHALL implement the state machine IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-013 SHALL accept start only in IDLE; on that edge it SHALL:
- capture dividend into Q;
- capture divisor into M;
- clear the signed WIDTH+1-bit accumulator A;
- clear the step counter;
- enter RUN.
REQ-014 SHALL perform exactly one non-restoring step on each RUN edge:
- shift {A,Q} left by one;
- if the old A >= 0, compute A = A - M; otherwise compute A = A + M;
- set Q[0] = ~A_new[WIDTH].
REQ-015 SHALL spend exactly WIDTH edges in RUN, then enter FIX.
REQ-016 SHALL, in FIX, apply the remainder correction: if A < 0, then A = A + M.
REQ-017 SHALL, on the FIX edge:
- load quotient = Q;
- load remainder = A[WIDTH-1:0];
- enter DONE.
REQ-018 SHALL assert done only during the DONE cycle, then return to IDLE.
REQ-019 SHALL give a latency of WIDTH+2 edges from the start-accept edge to the first cycle in which done is high.
REQ-020 SHALL ignore start while busy, with no effect on state or on the captured operands.
REQ-021 SHALL hold quotient, remainder and dbz after done until the next completion.
REQ-022 SHALL use a WIDTH+1-bit sign-extended add/sub with no overflow loss; result bits are WIDTH wide.
REQ-023 SHALL treat divisor = 0 as follows when the Configuration feature is absent:
- the algorithm runs normally;
- it yields quotient = all ones and remainder = dividend.

Reset
REQ-024 SHALL, while rst is high at an edge, force:
- state to IDLE;
- busy = 0, done = 0, dbz = 0;
- quotient = 0, remainder = 0;
- A, Q, M and the counter to 0.
REQ-025 SHALL abort any division in progress when rst is applied mid-operation, with no done pulse.
REQ-026 SHALL give rst priority over start on the same edge.

Configuration
REQ-027 SHALL recognise the macro NONRESTORING_DIVIDER_DBZ_EN.
REQ-028 SHALL, with the macro defined, handle start in IDLE with divisor = 0 as follows:
- go directly to DONE;
- load quotient = all ones and remainder = dividend;
- set dbz = 1;
- done appears 1 edge after accept.
REQ-029 SHALL, with the macro undefined, tie dbz to 0 and give every division WIDTH+2 latency.

Structure
REQ-030 SHALL place the state enum typedef and the default WIDTH constant in the shared package booth_pkg.
REQ-031 SHALL instantiate exactly one combinational sub-module div_step:
- inputs: A, Q, M;
- outputs: next A and next Q for one iteration;
- the FSM, counter and registers stay in the top level.

Verification
REQ-032 SHALL cover, with WIDTH=4: start with 13/3 -> done 6 edges after accept, quotient=4, remainder=1, dbz=0.
REQ-033 SHALL cover, with WIDTH=4: 7/9 -> quotient=0, remainder=7; 15/15 -> quotient=1, remainder=0; 0/5 -> quotient=0, remainder=0.
REQ-034 SHALL cover 11/0, both configurations:
- macro defined: quotient=15, remainder=11, dbz=1, done 1 edge after accept;
- macro undefined: quotient=15, remainder=11, dbz=0, done after 6 edges.
REQ-035 SHALL cover, with WIDTH=4: start 13/3, then start 9/2 pulsed on the 3rd busy cycle -> result still 4/1, and no second done pulse.
REQ-036 SHALL cover, with WIDTH=4: rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, quotient=0, remainder=0; then 14/4 gives quotient=3, remainder=2.
REQ-037 SHALL cover, with WIDTH=4: an exhaustive sweep of all 256 dividend/divisor pairs, checking quotient*divisor + remainder == dividend and remainder < divisor for divisor != 0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the non-restoring divider: default width and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package booth_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division iteration on {A,Q} against divisor M.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module div_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;

    // Shift {A,Q} left, add or subtract M depending on the sign of the old A,
    // and shift the new quotient bit (inverted sign of the new A) into Q.
    // The shifted A can exceed the WIDTH+1-bit range, but the true result lies
    // in [-M, M), so modular WIDTH+1-bit arithmetic still gives the exact value.
    always_comb begin
        a_sh  = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        m_ext = {1'b0, m_in};
        if (a_in[WIDTH]) begin
            a_out = a_sh + m_ext;
        end else begin
            a_out = a_sh - m_ext;
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle unsigned non-restoring divider; optional divide-by-zero shortcut via NONRESTORING_DIVIDER_DBZ_EN.
// Latency: WIDTH+2 edges from start accept to done (1 edge for divisor 0 when the shortcut is built in).
// Backpressure: start is only honoured while idle; requests while busy are dropped without effect.
module nonrestoring_divider
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH:0]   a_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .a_in  (a_q),
        .q_in  (q_q),
        .m_in  (m_q),
        .a_out (step_a),
        .q_out (step_q)
    );

    // Final remainder correction: a negative partial remainder gets M added back.
    always_comb begin
        if (a_q[WIDTH]) begin
            a_fix = a_q + {1'b0, m_q};
        end else begin
            a_fix = a_q;
        end
    end

    // Next-state logic for the FSM, datapath registers and result registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    m_d   = divisor;
                    a_d   = '0;
                    cnt_d = '0;
`ifdef NONRESTORING_DIVIDER_DBZ_EN
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                a_d     = a_fix;
                quo_d   = q_q;
                rem_d   = a_fix[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef NONRESTORING_DIVIDER_DBZ_EN
    assign dbz       = dbz_q;
`else
    // Without the shortcut, divide-by-zero is not flagged; the register is kept
    // only so the datapath is identical in both builds.
    assign dbz       = 1'b0;
    logic unused_dbz;
    assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
module tb_nonrestoring_divider;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int n_tests = 0;
    int n_fail  = 0;

    nonrestoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp_q;
        int exp_r;
        int exp_z;
        int exp_lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all ones / dividend.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int z, output int lat);
        if (b == 0) begin
            q = MAXV;
            r = a;
`ifdef NONRESTORING_DIVIDER_DBZ_EN
            z = 1;
            lat = 1;
`else
            z = 0;
            lat = W + 2;
`endif
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
            lat = W + 2;
        end
    endfunction

    // Issue one division from IDLE, count edges (accept edge = 1) until done,
    // then step one more edge so the DUT is back in IDLE.
    task automatic do_div(input int a, input int b, output int q, output int r,
                          output int z, output int lat, output int to,
                          output int done_after, output int busy_after);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        lat = 0;
        to  = 1;
        q = 0; r = 0; z = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) begin
                to = 0;
                q  = int'(quotient);
                r  = int'(remainder);
                z  = int'(dbz);
                break;
            end
        end
        @(posedge clk);
        #1;
        done_after = int'(done);
        busy_after = int'(busy);
    endtask

    vec_t vecs[6];

    initial begin
        int q, r, z, lat, to, da, ba;
        int eq, er, ez, elat;
        int ndone;

        vecs[0] = '{a: 13, b: 3,  exp_q: 4,  exp_r: 1,  exp_z: 0, exp_lat: 6};
        vecs[1] = '{a: 7,  b: 9,  exp_q: 0,  exp_r: 7,  exp_z: 0, exp_lat: 6};
        vecs[2] = '{a: 15, b: 15, exp_q: 1,  exp_r: 0,  exp_z: 0, exp_lat: 6};
        vecs[3] = '{a: 0,  b: 5,  exp_q: 0,  exp_r: 0,  exp_z: 0, exp_lat: 6};
        vecs[4] = '{a: 14, b: 4,  exp_q: 3,  exp_r: 2,  exp_z: 0, exp_lat: 6};
`ifdef NONRESTORING_DIVIDER_DBZ_EN
        vecs[5] = '{a: 11, b: 0,  exp_q: 15, exp_r: 11, exp_z: 1, exp_lat: 1};
`else
        vecs[5] = '{a: 11, b: 0,  exp_q: 15, exp_r: 11, exp_z: 0, exp_lat: 6};
`endif

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dbz", int'(dbz), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_div(vecs[i].a, vecs[i].b, q, r, z, lat, to, da, ba);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].exp_r);
            check($sformatf("vec%0d_dbz", i), z, vecs[i].exp_z);
            check($sformatf("vec%0d_done_one_cycle", i), da, 0);
            check($sformatf("vec%0d_idle_after", i), ba, 0);
        end

        // Start while busy is ignored: 13/3, then 9/2 pulsed on the 3rd busy cycle
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        lat = 0;
        to  = 1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (lat == 3) begin
                dividend = 4'd9;
                divisor  = 4'd2;
                start    = 1'b1;
            end
            if (done) begin
                to = 0;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_timeout", to, 0);
        check("busy_start_latency", lat, 6);
        check("busy_start_quotient", int'(quotient), 4);
        check("busy_start_remainder", int'(remainder), 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("busy_start_no_second_done", ndone, 0);

        // Reset during the 2nd RUN cycle aborts the division
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        do_div(14, 4, q, r, z, lat, to, da, ba);
        check("postrst_timeout", to, 0);
        check("postrst_quotient", q, 3);
        check("postrst_remainder", r, 2);

        // Reset wins over start on the same edge
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_over_start_busy", int'(busy), 0);

        // Exhaustive sweep
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                do_div(a, b, q, r, z, lat, to, da, ba);
                model(a, b, eq, er, ez, elat);
                if (b != 0) begin
                    check($sformatf("sweep_%0d_%0d_identity", a, b),
                          int'((q * b + r == a) && (r < b)), 1);
                end else begin
                    check($sformatf("sweep_%0d_0_result", a), q * 16 + r, eq * 16 + er);
                end
                check($sformatf("sweep_%0d_%0d_latency", a, b), lat, elat);
            end
        end

        // Randomized against the reference model, with random idle gaps
        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = int'($urandom_range(MAXV, 0));
            b = int'($urandom_range(MAXV, 0));
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            do_div(a, b, q, r, z, lat, to, da, ba);
            model(a, b, eq, er, ez, elat);
            check($sformatf("rand_%0d_%0d_quotient", a, b), q, eq);
            check($sformatf("rand_%0d_%0d_remainder", a, b), r, er);
            check($sformatf("rand_%0d_%0d_dbz", a, b), z, ez);
            check($sformatf("rand_%0d_%0d_latency", a, b), lat, elat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
